// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the demux frame router
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_lane_pick.sv
// rtl/rr_lane_pick.sv - first enabled lane at or after rr_ptr, wrapping
module rr_lane_pick
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] rr_ptr,
    input  logic [LANES-1:0] lane_en,
    output logic [SEL_W-1:0] target,
    output logic             any_en
);

    logic [2*LANES-1:0] en_dbl;
    logic [LANES-1:0]   en_rot;

    // Doubling the mask turns the wrap-around search into a plain slice.
    always_comb begin
        en_dbl = {lane_en, lane_en};
        en_rot = en_dbl[rr_ptr +: LANES];
        any_en = |lane_en;
        target = rr_ptr;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (en_rot[k]) begin
                target = rr_ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/demux_frame_router.sv
// rtl/demux_frame_router.sv - per-frame lane selection and output register for the 1x4 demux
module demux_frame_router
    import demux_pkg::*;
#(
    parameter int W      = 1,
    parameter int DCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_data,
    input  logic              s_last,
    input  logic              mode,
    input  logic [LANES-1:0]  lane_en,
    input  logic [LANES-1:0]  lane_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic [DCNT_W-1:0] drop_cnt
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [W-1:0]        dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [SEL_W-1:0]    rr_q, rr_d;
    logic [DCNT_W-1:0]   drop_cnt_q;
    logic                cnt_inc;
    logic                out_free;
    logic [SEL_W-1:0]    rr_target;
    logic                rr_any;
    logic [SEL_W-1:0]    hdr_tgt;

    rr_lane_pick u_pick (
        .rr_ptr (rr_q),
        .lane_en(lane_en),
        .target (rr_target),
        .any_en (rr_any)
    );

    if (W >= SEL_W) begin : g_hdr
        assign hdr_tgt = s_data[SEL_W-1:0];
    end else begin : g_hdr_narrow
        assign hdr_tgt = SEL_W'(s_data);
    end

    assign out_free = !valid_q || lane_ready[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        rr_d    = rr_q;
        cnt_inc = 1'b0;
        s_ready = out_free;

        if (valid_q && lane_ready[sel_q]) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Header accept is gated too: sel may move under a pending beat otherwise.
                s_ready = out_free;
                if (s_valid && out_free) begin
                    if (mode == MODE_RR) begin
                        if (!rr_any) begin
                            cnt_inc = 1'b1;
                            if (!s_last) state_d = DROP;
                        end else begin
                            dout_d  = s_data;
                            last_d  = s_last;
                            valid_d = 1'b1;
                            sel_d   = rr_target;
                            rr_d    = rr_target + SEL_W'(1);
                            if (!s_last) state_d = ROUTE;
                        end
                    end else if (!s_last) begin
                        if (!lane_en[hdr_tgt]) begin
                            cnt_inc = 1'b1;
                            state_d = DROP;
                        end else begin
                            sel_d   = hdr_tgt;
                            state_d = ROUTE;
                        end
                    end
                end
            end
            ROUTE: begin
                s_ready = out_free;
                if (s_valid && out_free) begin
                    dout_d  = s_data;
                    last_d  = s_last;
                    valid_d = 1'b1;
                    if (s_last) state_d = IDLE;
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            rr_q       <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            rr_q    <= rr_d;
            if (cnt_inc && drop_cnt_q != {DCNT_W{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + DCNT_W'(1);
            end
        end
    end

    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux_frame_router.sv
// tb/tb_demux_frame_router.sv - scoreboard bench for demux_frame_router
module tb_demux_frame_router;

    localparam int W      = 8;
    localparam int DCNT_W = 8;
    localparam int DMAX   = (1 << DCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [W-1:0]      s_data = '0;
    logic              s_last = 1'b0;
    logic              mode = 1'b0;
    logic [3:0]        lane_en = 4'hf;
    logic [3:0]        lane_ready = 4'hf;
    logic [1:0]        sel;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_last;
    logic [DCNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    demux_frame_router #(.W(W), .DCNT_W(DCNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mode      (mode),
        .lane_en   (lane_en),
        .lane_ready(lane_ready),
        .sel       (sel),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Frame-level reference: where the frame goes, how many frames were dropped.
    int    m_rr = 0;
    int    m_drops = 0;
    int    m_cur = 0;
    bit    m_in = 0;
    bit    m_drop = 0;

    bit    lr_rand = 0;
    logic [3:0] lr_force = 4'hf;

    bit    hold_v = 0;
    beat_t hold_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_beat(input logic md, input logic [3:0] en,
                              input logic [W-1:0] d, input logic l);
        int t;
        beat_t b;
        if (!m_in) begin
            if (md == 1'b0) begin
                t = -1;
                for (int k = 0; k < 4; k++) begin
                    if (t < 0 && en[(m_rr + k) % 4]) t = (m_rr + k) % 4;
                end
                if (t < 0) begin
                    if (m_drops < DMAX) m_drops++;
                    m_drop = 1;
                end else begin
                    b.sel = 2'(t); b.data = d; b.last = l;
                    exp_q.push_back(b);
                    m_rr = (t + 1) % 4;
                    m_cur = t;
                    m_drop = 0;
                end
                m_in = !l;
            end else if (!l) begin
                t = int'(d[1:0]);
                m_in = 1;
                if (!en[t]) begin
                    if (m_drops < DMAX) m_drops++;
                    m_drop = 1;
                end else begin
                    m_cur = t;
                    m_drop = 0;
                end
            end
        end else begin
            if (!m_drop) begin
                b.sel = 2'(m_cur); b.data = d; b.last = l;
                exp_q.push_back(b);
            end
            if (l) m_in = 0;
        end
    endtask

    // Stimulus side: every accepted beat feeds the model, which queues expected output.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_rr = 0; m_drops = 0; m_in = 0; m_drop = 0;
        end else begin
            if (s_valid && m_in && m_drop) chk("drop_ready", s_ready, 1);
            if (dout_valid && !lane_ready[sel] && !(m_in && m_drop)) chk("bp_ready", s_ready, 0);
            if (s_valid && s_ready) model_beat(mode, lane_en, s_data, s_last);
        end
    end

    // Monitor: pops on every consumed beat, and checks that stalled beats stay put.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_sel", sel, hold_b.sel);
                chk("hold_data", dout, hold_b.data);
                chk("hold_last", dout_last, hold_b.last);
            end
            hold_v = 0;
            if (dout_valid && !lane_ready[sel]) begin
                hold_v = 1;
                hold_b.sel = sel; hold_b.data = dout; hold_b.last = dout_last;
            end
            if (dout_valid && lane_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat sel=%0d dout=%0h last=%0b expected none t=%0t",
                             sel, dout, dout_last, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sel", sel, e.sel);
                    chk("out_data", dout, e.data);
                    chk("out_last", dout_last, e.last);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        lane_ready = lr_rand ? 4'($urandom) : lr_force;
    end

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=stalled required=accept t=%0t", $time);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit hdr, input logic [1:0] tgt);
        logic [W-1:0] h;
        if (hdr) begin
            h = W'($urandom);
            h[1:0] = tgt;
            send_beat(h, n == 0);
        end
        for (int i = 0; i < n; i++) send_beat(W'($urandom), i == n - 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        lr_rand = 0; lr_force = 4'hf; s_valid = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || dout_valid); i++) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("dout_idle", dout_valid, 0);
        chk("drop_cnt", drop_cnt, m_drops);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round-robin across all lanes, wrapping back to lane 0.
        mode = 1'b0; lane_en = 4'hf;
        for (int f = 0; f < 5; f++) send_frame(1, 0, 2'd0);
        drain();

        do_reset();
        lane_en = 4'b0101;
        for (int f = 0; f < 3; f++) send_frame(1, 0, 2'd0);
        drain();

        // Addressed frame to lane 3, header must not appear.
        mode = 1'b1; lane_en = 4'hf;
        send_frame(3, 1, 2'd3);
        drain();

        // Addressed to a disabled lane, then round-robin with nothing enabled.
        lane_en = 4'b1101;
        send_frame(4, 1, 2'd1);
        mode = 1'b0; lane_en = 4'b0000;
        send_frame(1, 0, 2'd0);
        send_frame(3, 0, 2'd0);
        drain();

        // Three cycles of backpressure on the active lane mid-frame.
        mode = 1'b1; lane_en = 4'hf;
        fork
            send_frame(6, 1, 2'd2);
            begin
                repeat (3) @(posedge clk);
                lr_force = 4'b1011;
                repeat (3) @(posedge clk);
                lr_force = 4'hf;
            end
        join
        drain();

        // Reset lands in ROUTE with a beat stalled on dout.
        lr_force = 4'b0111;
        repeat (2) @(posedge clk);
        #1;
        mode = 1'b1; lane_en = 4'hf;
        send_beat(8'h03, 1'b0);
        send_beat(8'h5a, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_sel", sel, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_last", dout_last, 0);
        chk("midrst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0; mode = 1'b0; lr_force = 4'hf;
        @(negedge clk);
        chk("postrst_valid", dout_valid, 0);
        chk("postrst_ready", s_ready, 1);
        drain();

        // Drop counter saturation.
        mode = 1'b0; lane_en = 4'b0000;
        for (int f = 0; f < DMAX - 1; f++) send_frame(1, 0, 2'd0);
        drain();
        send_frame(1, 0, 2'd0);
        drain();
        chk("sat_at_max", drop_cnt, DMAX);
        send_frame(2, 0, 2'd0);
        drain();
        chk("sat_hold", drop_cnt, DMAX);

        // Randomized frames, modes and enables shuffled between every beat.
        do_reset();
        lr_rand = 1;
        for (int f = 0; f < 300; f++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                mode = 1'($urandom);
                lane_en = 4'($urandom);
                send_beat(W'($urandom), i == n - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
